// File: rtl/output_port_cluster_n_if.sv
// output_port_cluster_n_if: per-channel user handshakes plus the merged internal packet stream
interface output_port_cluster_n_if #(
    parameter int NUM_OUT_PORTS = 4,
    parameter int DATA_USER_OUT = 32,
    parameter int PACKET_BITS   = 43
);
    logic [DATA_USER_OUT*NUM_OUT_PORTS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]               vld_user2b_out;
    logic [NUM_OUT_PORTS-1:0]               ack_b_out2user;
    logic [PACKET_BITS-1:0]                 internal_out;
    logic                                   internal_vld;
    logic                                   internal_rdy;

    modport master (
        output din_leaf_user2interface, vld_user2b_out, internal_rdy,
        input  ack_b_out2user, internal_out, internal_vld
    );

    modport slave (
        input  din_leaf_user2interface, vld_user2b_out, internal_rdy,
        output ack_b_out2user, internal_out, internal_vld
    );
endinterface

// File: rtl/output_port_cluster_n.sv
// output_port_cluster_n: per-channel user FIFOs packetised and merged round-robin onto one credit-controlled NoC stream
module output_port_cluster_n #(
    parameter int NUM_OUT_PORTS = 4,
    parameter int PORT_IDX_BITS = 2,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int DATA_USER_OUT = 32,
    parameter int FIFO_DEPTH    = 8,
    parameter int CREDIT_BITS   = 7,
    parameter int CNT_BITS      = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cfg_we,
    input  logic [PORT_IDX_BITS-1:0]          cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]          cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]          cfg_dst_port,
    input  logic [CREDIT_BITS-1:0]            cfg_credit,
    input  logic                              credit_ret_vld,
    input  logic [PORT_IDX_BITS-1:0]          credit_ret_port,
    input  logic [CREDIT_BITS-1:0]            credit_ret_amt,
    output_port_cluster_n_if.slave            bus,
    input  logic                              cnt_clr,
    output logic [CNT_BITS*NUM_OUT_PORTS-1:0] output_port_full_cnt,
    output logic                              output_port_cluster_stall_condition
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = NUM_LEAF_BITS + NUM_PORT_BITS + DATA_USER_OUT;

    logic [NUM_OUT_PORTS*HW-1:0] heads;
    logic [NUM_OUT_PORTS-1:0]    elig, starve;
    logic [PORT_IDX_BITS-1:0]    rr_ptr, gnt_idx;
    logic [HW-1:0]               gnt_head;
    logic                        gnt_any, load;

    assign load    = !bus.internal_vld || bus.internal_rdy;
    assign gnt_any = |elig;
    assign output_port_cluster_stall_condition = |starve;

    // scanning distances from far to near leaves the closest eligible channel after rr_ptr
    always_comb begin
        gnt_idx  = '0;
        gnt_head = '0;
        for (int k = NUM_OUT_PORTS - 1; k >= 0; k--)
            for (int c = 0; c < NUM_OUT_PORTS; c++)
                if (elig[c] && c == (int'(rr_ptr) + k) % NUM_OUT_PORTS) gnt_idx = PORT_IDX_BITS'(c);
        for (int c = 0; c < NUM_OUT_PORTS; c++)
            if (gnt_idx == PORT_IDX_BITS'(c)) gnt_head = heads[c*HW +: HW];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.internal_vld <= 1'b0;
            bus.internal_out <= '0;
            rr_ptr           <= '0;
        end else if (load) begin
            bus.internal_vld <= gnt_any;
            if (gnt_any) begin
                bus.internal_out <= {1'b1, gnt_head};
                rr_ptr           <= PORT_IDX_BITS'((int'(gnt_idx) + 1) % NUM_OUT_PORTS);
            end
        end
    end

    for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_ch
        logic [DATA_USER_OUT-1:0] mem [FIFO_DEPTH];
        logic [AW:0]              wp, rp;
        logic [CREDIT_BITS-1:0]   credit;
        logic [NUM_LEAF_BITS-1:0] dst_leaf;
        logic [NUM_PORT_BITS-1:0] dst_port;
        logic [CNT_BITS-1:0]      cnt;
        logic [CREDIT_BITS:0]     sum;
        logic                     configured, empty, full, push, pop, sel_cfg, sel_ret, stalled;

        assign empty    = wp == rp;
        assign full     = wp == {~rp[AW], rp[AW-1:0]};
        assign bus.ack_b_out2user[i] = !reset && !full;
        assign push     = bus.vld_user2b_out[i] && bus.ack_b_out2user[i];
        assign stalled  = bus.vld_user2b_out[i] && !bus.ack_b_out2user[i];
        assign sel_cfg  = cfg_we && cfg_port == PORT_IDX_BITS'(i);
        assign sel_ret  = credit_ret_vld && credit_ret_port == PORT_IDX_BITS'(i);
        assign elig[i]  = !empty && configured && credit != '0 && !sel_cfg;
        assign starve[i] = !empty && credit == '0;
        assign pop      = load && gnt_any && gnt_idx == PORT_IDX_BITS'(i);
        // a grant only happens with credit > 0, so the subtraction cannot underflow
        assign sum      = {1'b0, credit} - {{CREDIT_BITS{1'b0}}, pop} + (sel_ret ? {1'b0, credit_ret_amt} : '0);
        assign heads[i*HW +: HW] = {dst_leaf, dst_port, mem[rp[AW-1:0]]};
        assign output_port_full_cnt[i*CNT_BITS +: CNT_BITS] = cnt;

        always_ff @(posedge clk)
            if (push) mem[wp[AW-1:0]] <= bus.din_leaf_user2interface[i*DATA_USER_OUT +: DATA_USER_OUT];

        always_ff @(posedge clk) begin
            if (reset) begin
                wp         <= '0;
                rp         <= '0;
                credit     <= '0;
                dst_leaf   <= '0;
                dst_port   <= '0;
                configured <= 1'b0;
                cnt        <= '0;
            end else begin
                wp <= wp + (AW+1)'(push);
                rp <= rp + (AW+1)'(pop);
                if (sel_cfg) begin
                    credit     <= cfg_credit;
                    dst_leaf   <= cfg_dst_leaf;
                    dst_port   <= cfg_dst_port;
                    configured <= 1'b1;
                end else begin
                    credit <= sum[CREDIT_BITS] ? '1 : sum[CREDIT_BITS-1:0];
                end
                cnt <= cnt_clr ? '0 : (stalled && !(&cnt)) ? cnt + CNT_BITS'(1) : cnt;
            end
        end
    end
endmodule

// File: tb/tb_output_port_cluster_n.sv
// tb_output_port_cluster_n: vector table plus directed sequences for the N-channel output cluster
module tb_output_port_cluster_n;
    localparam int N = 4, LB = 6, PB = 4, DW = 32, CB = 7, CW = 32, PKB = 1 + LB + PB + DW;

    typedef struct {
        logic        cfg;
        logic        ret;
        logic        vld;
        logic [31:0] d;
        logic        rdy;
        logic        e_vld;
        logic [31:0] e_d;
        logic        e_stall;
    } vec_t;

    logic          clk = 1'b0, reset = 1'b1, cfg_we, credit_ret_vld, cnt_clr;
    logic [1:0]    cfg_port, credit_ret_port;
    logic [LB-1:0] cfg_dst_leaf;
    logic [PB-1:0] cfg_dst_port;
    logic [CB-1:0] cfg_credit, credit_ret_amt;
    logic [CW*N-1:0] full_cnt;
    logic          stall;
    vec_t          tv [15];
    int            n_cmp = 0, n_bad = 0, got, acc;
    logic [DW-1:0] last_d;

    always #5 clk = ~clk;

    output_port_cluster_n_if #(.NUM_OUT_PORTS(N), .DATA_USER_OUT(DW), .PACKET_BITS(PKB)) bus ();

    output_port_cluster_n #(
        .NUM_OUT_PORTS(N), .PORT_IDX_BITS(2), .NUM_LEAF_BITS(LB), .NUM_PORT_BITS(PB),
        .DATA_USER_OUT(DW), .FIFO_DEPTH(8), .CREDIT_BITS(CB), .CNT_BITS(CW)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_port(cfg_port),
        .cfg_dst_leaf(cfg_dst_leaf), .cfg_dst_port(cfg_dst_port), .cfg_credit(cfg_credit),
        .credit_ret_vld(credit_ret_vld), .credit_ret_port(credit_ret_port), .credit_ret_amt(credit_ret_amt),
        .bus(bus), .cnt_clr(cnt_clr), .output_port_full_cnt(full_cnt),
        .output_port_cluster_stall_condition(stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PKB-1:0] pk(input logic [LB-1:0] l, input logic [PB-1:0] p, input logic [DW-1:0] d);
        return {1'b1, l, p, d};
    endfunction

    function automatic logic [31:0] dat(input int c, input int j);
        return 32'hA000_0000 | 32'(c << 4) | 32'(j);
    endfunction

    task automatic idle();
        cfg_we = 1'b0; cfg_port = 2'd0; cfg_dst_leaf = '0; cfg_dst_port = '0; cfg_credit = '0;
        credit_ret_vld = 1'b0; credit_ret_port = 2'd0; credit_ret_amt = '0; cnt_clr = 1'b0;
        bus.vld_user2b_out = '0; bus.din_leaf_user2interface = '0; bus.internal_rdy = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic cfg(input int ch, input int l, input int p, input int c);
        cfg_we = 1'b1; cfg_port = 2'(ch); cfg_dst_leaf = 6'(l); cfg_dst_port = 4'(p); cfg_credit = 7'(c);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic ret(input int ch, input int amt);
        credit_ret_vld = 1'b1; credit_ret_port = 2'(ch); credit_ret_amt = 7'(amt);
        step();
        credit_ret_vld = 1'b0;
    endtask

    task automatic put(input int ch, input logic [31:0] d);
        bus.din_leaf_user2interface[ch*DW +: DW] = d;
        bus.vld_user2b_out[ch] = 1'b1;
    endtask

    task automatic tick();
        step();
        if (bus.internal_vld && bus.internal_rdy) begin
            got++;
            last_d = bus.internal_out[DW-1:0];
        end
    endtask

    initial begin
        tv[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tv[1]  = '{1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0, 32'h0,        1'b0};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b1, 32'h11111111, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h22222222, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 32'h33333333, 1'b1, 1'b0, 32'h0,        1'b0};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 32'h44444444, 1'b1, 1'b1, 32'h33333333, 1'b1};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1};
        tv[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tv[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h44444444, 1'b0};
        tv[12] = '{1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 1'b1, 32'h44444444, 1'b1};
        tv[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h44444444, 1'b1};
        tv[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1};

        idle();
        reset = 1'b1;
        step();
        step();
        check("rst_vld", 64'(bus.internal_vld), 64'd0);
        check("rst_out", 64'(bus.internal_out), 64'd0);
        check("rst_ack", 64'(bus.ack_b_out2user), 64'd0);
        check("rst_cnt", 64'(full_cnt[CW-1:0]), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        reset = 1'b0;
        step();
        check("rst_rel_ack", 64'(bus.ack_b_out2user), 64'hF);

        // single-channel vectors: config, latency, credit exhaustion, return, hold under back-pressure
        for (int i = 0; i < 15; i++) begin
            cfg_we = tv[i].cfg; cfg_port = 2'd0; cfg_dst_leaf = 6'd5; cfg_dst_port = 4'd2; cfg_credit = 7'd4;
            credit_ret_vld = tv[i].ret; credit_ret_port = 2'd0; credit_ret_amt = 7'd1;
            bus.vld_user2b_out = {3'b000, tv[i].vld};
            bus.din_leaf_user2interface[DW-1:0] = tv[i].d;
            bus.internal_rdy = tv[i].rdy;
            step();
            check($sformatf("vec%0d_vld", i), 64'(bus.internal_vld), 64'(tv[i].e_vld));
            if (tv[i].e_vld) check($sformatf("vec%0d_out", i), 64'(bus.internal_out), 64'(pk(6'd5, 4'd2, tv[i].e_d)));
            check($sformatf("vec%0d_ack", i), 64'(bus.ack_b_out2user), 64'hF);
            check($sformatf("vec%0d_stall", i), 64'(stall), 64'(tv[i].e_stall));
        end

        // round-robin across four channels, two words each
        do_reset();
        for (int c = 0; c < N; c++) cfg(c, 10 + c, c, 8);
        for (int j = 0; j < 2; j++) begin
            for (int c = 0; c < N; c++) put(c, dat(c, j));
            step();
        end
        bus.vld_user2b_out = '0;
        for (int n = 0; n < 8; n++) begin
            check("rr_vld", 64'(bus.internal_vld), 64'd1);
            check("rr_out", 64'(bus.internal_out), 64'(pk(6'(10 + n % 4), 4'(n % 4), dat(n % 4, n / 4))));
            step();
        end
        check("rr_end_vld", 64'(bus.internal_vld), 64'd0);

        // credit-limited channel, then credit return
        do_reset();
        cfg(1, 1, 1, 2);
        got = 0;
        for (int k = 0; k < 5; k++) begin
            put(1, 32'h300 + 32'(k));
            tick();
        end
        bus.vld_user2b_out = '0;
        for (int k = 0; k < 10; k++) tick();
        check("cred_pkts", 64'(got), 64'd2);
        check("cred_stall", 64'(stall), 64'd1);
        got = 0;
        ret(1, 3);
        for (int k = 0; k < 10; k++) tick();
        check("ret_pkts", 64'(got), 64'd3);
        check("ret_last", 64'(last_d), 64'h304);
        check("ret_stall", 64'(stall), 64'd0);

        // back-pressure: FIFO plus output register fill, stall counting, clear, drain
        do_reset();
        cfg(0, 7, 1, 100);
        bus.internal_rdy = 1'b0;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            put(0, 32'h1000 + 32'(acc));
            if (bus.ack_b_out2user[0]) acc++;
            step();
            if (k >= 1) begin
                check("bp_vld", 64'(bus.internal_vld), 64'd1);
                check("bp_hold", 64'(bus.internal_out), 64'(pk(6'd7, 4'd1, 32'h1000)));
            end
        end
        bus.vld_user2b_out = '0;
        check("bp_accepts", 64'(acc), 64'd9);
        check("bp_ack0", 64'(bus.ack_b_out2user[0]), 64'd0);
        check("bp_cnt0", 64'(full_cnt[CW-1:0]), 64'd11);
        check("bp_cnt1", 64'(full_cnt[2*CW-1:CW]), 64'd0);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("bp_clr", 64'(full_cnt[CW-1:0]), 64'd0);
        bus.internal_rdy = 1'b1;
        got = 0;
        for (int k = 0; k < 15; k++) begin
            if (bus.internal_vld) begin
                check("drain_d", 64'(bus.internal_out), 64'(pk(6'd7, 4'd1, 32'h1000 + 32'(got))));
                got++;
            end
            step();
        end
        check("drain_cnt", 64'(got), 64'd9);

        // grant and return in one cycle; config write blocks a grant in the same cycle
        do_reset();
        cfg(2, 2, 2, 3);
        put(2, 32'h500);
        step();
        bus.vld_user2b_out = '0;
        ret(2, 2);
        check("gr_vld", 64'(bus.internal_vld), 64'd1);
        check("gr_out", 64'(bus.internal_out), 64'(pk(6'd2, 4'd2, 32'h500)));
        got = 0;
        for (int k = 0; k < 6; k++) begin
            put(2, 32'h501 + 32'(k));
            tick();
        end
        bus.vld_user2b_out = '0;
        for (int k = 0; k < 8; k++) tick();
        check("gr_pkts", 64'(got), 64'd4);
        check("gr_stall", 64'(stall), 64'd1);
        ret(2, 1);
        check("cfgblk_pre", 64'(bus.internal_vld), 64'd0);
        cfg(2, 9, 3, 6);
        check("cfgblk_vld", 64'(bus.internal_vld), 64'd0);
        step();
        check("cfgblk_next_vld", 64'(bus.internal_vld), 64'd1);
        check("cfgblk_next_out", 64'(bus.internal_out), 64'(pk(6'd9, 4'd3, 32'h505)));
        got = 1;
        for (int k = 0; k < 6; k++) begin
            put(2, 32'h507 + 32'(k));
            tick();
        end
        bus.vld_user2b_out = '0;
        for (int k = 0; k < 10; k++) tick();
        check("cfg_pkts", 64'(got), 64'd6);
        check("cfg_stall", 64'(stall), 64'd1);

        // reset mid-operation drops the in-flight packet and queued words
        do_reset();
        cfg(0, 1, 1, 5);
        cfg(1, 2, 2, 5);
        bus.internal_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            put(0, 32'h600 + 32'(k));
            put(1, 32'h610 + 32'(k));
            step();
        end
        bus.vld_user2b_out = '0;
        check("mr_pre_vld", 64'(bus.internal_vld), 64'd1);
        reset = 1'b1;
        step();
        check("mr_vld", 64'(bus.internal_vld), 64'd0);
        check("mr_out", 64'(bus.internal_out), 64'd0);
        check("mr_ack", 64'(bus.ack_b_out2user), 64'd0);
        reset = 1'b0;
        step();
        check("mr_rel_ack", 64'(bus.ack_b_out2user), 64'hF);
        check("mr_rel_stall", 64'(stall), 64'd0);
        bus.internal_rdy = 1'b1;
        cfg(0, 1, 1, 5);
        cfg(1, 2, 2, 5);
        got = 0;
        for (int k = 0; k < 6; k++) tick();
        check("mr_no_stale", 64'(got), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
